// File: rtl/spectrum_feeder.sv
// spectrum_feeder: buffers one voice and one SD reference FFT frame, then
// replays both bin-by-bin in lock-step to the spectral evaluator and turns
// its done/result reply into the receiving/correct pulse pair for the scorer.
// Optional feature macro: SPECTRUM_FEEDER_DC_SKIP_EN (stream bin 0 as zero).
module spectrum_feeder #(
  parameter int unsigned BINS    = 256,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_voice_valid,
  input  logic [DW-1:0] i_voice_real,
  input  logic [DW-1:0] i_voice_imag,
  output logic          o_voice_ready,
  input  logic          i_sd_valid,
  input  logic [DW-1:0] i_sd_real,
  input  logic [DW-1:0] i_sd_imag,
  output logic          o_sd_ready,
  output logic          o_start,
  output logic [DW-1:0] o_voice_freq_real,
  output logic [DW-1:0] o_voice_freq_imag,
  output logic [DW-1:0] o_sd_freq_real,
  output logic [DW-1:0] o_sd_freq_imag,
  input  logic          i_eval_done,
  input  logic          i_eval_result,
  output logic          o_receiving,
  output logic          o_correct,
  output logic          o_timeout,
  output logic          o_busy
);

  localparam int unsigned AW = $clog2(BINS);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_FILL, S_START, S_STREAM, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] v_ptr_q, v_ptr_d, s_ptr_q, s_ptr_d, rd_q, rd_d;
  logic          v_rdy_q, v_rdy_d, s_rdy_q, s_rdy_d;
  logic          last_q, last_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          start_q, start_d, recv_q, recv_d, corr_q, corr_d;
  logic          tmo_q, tmo_d, busy_q, busy_d;
  logic [DW-1:0] vr_q, vr_d, vi_q, vi_d, sr_q, sr_d, si_q, si_d;
  logic          v_we, s_we;

  logic [DW-1:0] v_re_mem [BINS];
  logic [DW-1:0] v_im_mem [BINS];
  logic [DW-1:0] s_re_mem [BINS];
  logic [DW-1:0] s_im_mem [BINS];

  // Frame buffers: contents need no reset, only the pointers do.
  always_ff @(posedge i_clk) begin
    if (v_we) begin
      v_re_mem[v_ptr_q] <= i_voice_real;
      v_im_mem[v_ptr_q] <= i_voice_imag;
    end
    if (s_we) begin
      s_re_mem[s_ptr_q] <= i_sd_real;
      s_im_mem[s_ptr_q] <= i_sd_imag;
    end
  end

  // State and registered-output update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_FILL;
      v_ptr_q <= '0;
      s_ptr_q <= '0;
      rd_q    <= '0;
      v_rdy_q <= 1'b1;
      s_rdy_q <= 1'b1;
      last_q  <= 1'b0;
      wcnt_q  <= '0;
      start_q <= 1'b0;
      recv_q  <= 1'b0;
      corr_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      vr_q    <= '0;
      vi_q    <= '0;
      sr_q    <= '0;
      si_q    <= '0;
    end else begin
      state_q <= state_d;
      v_ptr_q <= v_ptr_d;
      s_ptr_q <= s_ptr_d;
      rd_q    <= rd_d;
      v_rdy_q <= v_rdy_d;
      s_rdy_q <= s_rdy_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      start_q <= start_d;
      recv_q  <= recv_d;
      corr_q  <= corr_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      vr_q    <= vr_d;
      vi_q    <= vi_d;
      sr_q    <= sr_d;
      si_q    <= si_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    v_ptr_d = v_ptr_q;
    s_ptr_d = s_ptr_q;
    rd_d    = rd_q;
    v_rdy_d = v_rdy_q;
    s_rdy_d = s_rdy_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    recv_d  = 1'b0;
    corr_d  = 1'b0;
    tmo_d   = 1'b0;
    vr_d    = '0;
    vi_d    = '0;
    sr_d    = '0;
    si_d    = '0;
    v_we    = 1'b0;
    s_we    = 1'b0;

    case (state_q)
      S_FILL: begin
        v_we = i_voice_valid && v_rdy_q;
        s_we = i_sd_valid && s_rdy_q;
        if (v_we) begin
          v_ptr_d = v_ptr_q + AW'(1);
          if (v_ptr_q == AW'(BINS - 1)) v_rdy_d = 1'b0;
        end
        if (s_we) begin
          s_ptr_d = s_ptr_q + AW'(1);
          if (s_ptr_q == AW'(BINS - 1)) s_rdy_d = 1'b0;
        end
        // Ready low on both sides means both frames are complete.
        if (!v_rdy_q && !s_rdy_q) state_d = S_START;
      end
      S_START, S_STREAM: begin
        if (state_q == S_STREAM && last_q) begin
          state_d = S_WAIT;
          last_d  = 1'b0;
          wcnt_d  = '0;
        end else begin
          state_d = S_STREAM;
          rd_d    = rd_q + AW'(1);
          last_d  = (rd_q == AW'(BINS - 1));
          vr_d    = v_re_mem[rd_q];
          vi_d    = v_im_mem[rd_q];
          sr_d    = s_re_mem[rd_q];
          si_d    = s_im_mem[rd_q];
`ifdef SPECTRUM_FEEDER_DC_SKIP_EN
          // Bin 0 is loaded only from S_START; blank it so DC never peaks.
          if (state_q == S_START) begin
            vr_d = '0;
            vi_d = '0;
            sr_d = '0;
            si_d = '0;
          end
`endif
        end
      end
      S_WAIT: begin
        if (i_eval_done) begin
          recv_d  = 1'b1;
          corr_d  = i_eval_result;
          state_d = S_FILL;
        end else if (wcnt_q == CW'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = S_FILL;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
    endcase

    // Re-arm both write sides on every return to S_FILL.
    if (state_q != S_FILL && state_d == S_FILL) begin
      v_ptr_d = '0;
      s_ptr_d = '0;
      rd_d    = '0;
      v_rdy_d = 1'b1;
      s_rdy_d = 1'b1;
    end

    start_d = (state_d == S_START);
    busy_d  = (state_d != S_FILL);
  end

  assign o_voice_ready     = v_rdy_q;
  assign o_sd_ready        = s_rdy_q;
  assign o_start           = start_q;
  assign o_voice_freq_real = vr_q;
  assign o_voice_freq_imag = vi_q;
  assign o_sd_freq_real    = sr_q;
  assign o_sd_freq_imag    = si_q;
  assign o_receiving       = recv_q;
  assign o_correct         = corr_q;
  assign o_timeout         = tmo_q;
  assign o_busy            = busy_q;

endmodule

// File: tb/tb_spectrum_feeder.sv
// Bench for spectrum_feeder: table of frame scenarios plus a mid-stream
// reset sequence; stream data is checked through per-side scoreboard queues.
`timescale 1ns/1ps
module tb_spectrum_feeder;

  localparam int NB = 256;
  localparam int DW = 16;
  localparam int NT = 15;
`ifdef SPECTRUM_FEEDER_DC_SKIP_EN
  localparam bit DC_SKIP = 1'b1;
`else
  localparam bit DC_SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          voice_valid, sd_valid;
  logic [DW-1:0] voice_real, voice_imag, sd_real, sd_imag;
  logic          voice_ready, sd_ready;
  logic          o_start;
  logic [DW-1:0] vfr, vfi, sfr, sfi;
  logic          eval_done, eval_result;
  logic          o_receiving, o_correct, o_timeout, o_busy;

  always #5 clk = ~clk;

  spectrum_feeder #(.BINS(NB), .DW(DW), .TIMEOUT(NT)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_voice_valid     (voice_valid),
    .i_voice_real      (voice_real),
    .i_voice_imag      (voice_imag),
    .o_voice_ready     (voice_ready),
    .i_sd_valid        (sd_valid),
    .i_sd_real         (sd_real),
    .i_sd_imag         (sd_imag),
    .o_sd_ready        (sd_ready),
    .o_start           (o_start),
    .o_voice_freq_real (vfr),
    .o_voice_freq_imag (vfi),
    .o_sd_freq_real    (sfr),
    .o_sd_freq_imag    (sfi),
    .i_eval_done       (eval_done),
    .i_eval_result     (eval_result),
    .o_receiving       (o_receiving),
    .o_correct         (o_correct),
    .o_timeout         (o_timeout),
    .o_busy            (o_busy)
  );

  typedef struct {
    string name;
    int    pat;       // 0 ramp, 1 random, 2 random with 0x7FFF in bin 0
    int    v_off;     // fill cycle at which voice writes start
    int    s_off;     // fill cycle at which SD writes start
    bit    reply;     // evaluator answers at all
    int    delay;     // wait-state cycle of the done strobe
    bit    result;
    bit    spur;      // stray done strobes outside S_WAIT
    bit    exp_recv;  // expect receiving (1) or timeout (0)
    bit    exp_corr;
    int    exp_fire;  // wait-state cycle of the expected pulse
  } vec_t;

  vec_t vecs[5];
  logic [2*DW-1:0] vq[$];
  logic [2*DW-1:0] sq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*DW-1:0] gen(input int pat, input int k, input bit sd);
    logic [2*DW-1:0] r;
    r = {DW'($urandom), DW'($urandom)};
    case (pat)
      0:       r = sd ? {DW'(2 * k), DW'(1)} : {DW'(k), DW'(0)};
      2:       if (k == 0) r = {DW'(16'h7FFF), DW'(16'h7FFF)};
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [2*DW-1:0] stream_exp(input int k, input logic [2*DW-1:0] d);
    if (DC_SKIP && k == 0) return '0;
    return d;
  endfunction

  // Fill both buffers, check start timing, stream and reply; abort_k >= 0
  // instead resets the DUT while bin abort_k is on the stream outputs.
  task automatic run_frame(input vec_t v, input int abort_k);
    int vn, sn, t, c_done, fill_bad, stream_bad, ctl_bad, first_k;
    int fire_recv, fire_tmo, n_recv, n_tmo;
    logic corr_seen, s1;
    logic [1:0] rdy_c1;
    logic [2:0] post_a, post_b;
    logic [2*DW-1:0] d, ev, es;
    logic [4*DW-1:0] first_act, first_exp;
    vq.delete();
    sq.delete();
    vn = 0; sn = 0; t = 0; c_done = -1; fill_bad = 0;
    while (c_done < 0 && t < 4 * NB) begin
      if (voice_ready !== (vn < NB)) fill_bad++;
      if (sd_ready !== (sn < NB)) fill_bad++;
      if (o_receiving !== 1'b0 || o_timeout !== 1'b0 || o_busy !== 1'b0) fill_bad++;
      voice_valid = (t >= v.v_off);
      d = (vn < NB) ? gen(v.pat, vn, 1'b0) : {DW'($urandom), DW'($urandom)};
      {voice_real, voice_imag} = d;
      if (voice_valid && vn < NB) begin
        vq.push_back(stream_exp(vn, d));
        vn++;
      end
      sd_valid = (t >= v.s_off);
      d = (sn < NB) ? gen(v.pat, sn, 1'b1) : {DW'($urandom), DW'($urandom)};
      {sd_real, sd_imag} = d;
      if (sd_valid && sn < NB) begin
        sq.push_back(stream_exp(sn, d));
        sn++;
      end
      eval_done   = v.spur && (t % 5 == 2);
      eval_result = 1'b1;
      if (vn == NB && sn == NB) c_done = t;
      step();
      t++;
    end
    voice_valid = 1'b0;
    sd_valid    = 1'b0;
    eval_done   = 1'b0;
    check({v.name, ":fill_done"}, 64'(c_done >= 0), 64'(1));
    check({v.name, ":fill_track"}, 64'(fill_bad), 64'(0));
    if (c_done < 0) return;

    // Cycle C+1: readies down, start not yet; cycle C+2 = T.
    s1 = o_start;
    rdy_c1 = {voice_ready, sd_ready};
    step();
    check({v.name, ":start_timing"}, 64'({s1, o_start}), 64'(2'b01));
    check({v.name, ":ready_low"}, 64'(rdy_c1), 64'(0));
    check({v.name, ":start_cycle"}, 64'({o_busy, vfr, vfi, sfr, sfi}), 64'({1'b1, 64'h0}));
    eval_done = v.spur;
    step();
    eval_done = 1'b0;

    stream_bad = 0; ctl_bad = 0; first_k = -1; first_act = '0; first_exp = '0;
    for (int k = 0; k < NB; k++) begin
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check({v.name, ":rst_stream"}, {vfr, vfi, sfr, sfi}, 64'(0));
        check({v.name, ":rst_ctrl"},
              64'({o_start, o_receiving, o_correct, o_timeout, o_busy, voice_ready, sd_ready}),
              64'(7'b0000011));
        step();
        step();
        rst_n = 1'b1;
        step();
        check({v.name, ":rst_release"}, 64'({voice_ready, sd_ready, o_busy, o_start}),
              64'(4'b1100));
        return;
      end
      ev = vq.pop_front();
      es = sq.pop_front();
      if ({vfr, vfi} !== ev || {sfr, sfi} !== es) begin
        if (first_k < 0) begin
          first_k   = k;
          first_act = {vfr, vfi, sfr, sfi};
          first_exp = {ev, es};
        end
        stream_bad++;
      end
      if (o_start !== 1'b0 || o_busy !== 1'b1 || o_receiving !== 1'b0) ctl_bad++;
      eval_done = v.spur && (k == 5);
      step();
    end
    eval_done = 1'b0;
    n_tests++;
    if (stream_bad != 0) begin
      n_fail++;
      $display("FAIL %s:stream %0d bins wrong, first bin %0d got %h expected %h",
               v.name, stream_bad, first_k, first_act, first_exp);
    end
    check({v.name, ":stream_ctrl"}, 64'(ctl_bad), 64'(0));
    check({v.name, ":stream_idle"}, {vfr, vfi, sfr, sfi}, 64'(0));

    // Wait phase: w = 0 is the first S_WAIT cycle.
    fire_recv = -1; fire_tmo = -1; n_recv = 0; n_tmo = 0; corr_seen = 1'b0;
    post_a = '0; post_b = '0;
    for (int w = 0; w < NT + 4; w++) begin
      eval_done   = v.reply && (w == v.delay);
      eval_result = v.result;
      if (o_receiving) begin
        n_recv++;
        if (fire_recv < 0) begin
          fire_recv = w;
          corr_seen = o_correct;
        end
      end
      if (o_timeout) begin
        n_tmo++;
        if (fire_tmo < 0) fire_tmo = w;
      end
      if (w == v.exp_fire)     post_a = {voice_ready, sd_ready, o_busy};
      if (w == v.exp_fire + 1) post_b = {voice_ready, sd_ready, o_busy};
      step();
    end
    eval_done = 1'b0;
    check({v.name, ":recv_cycle"}, 64'(fire_recv), 64'(v.exp_recv ? v.exp_fire : -1));
    check({v.name, ":recv_count"}, 64'(n_recv), 64'(v.exp_recv ? 1 : 0));
    check({v.name, ":correct"}, 64'(corr_seen), 64'(v.exp_recv ? v.exp_corr : 1'b0));
    check({v.name, ":tmo_cycle"}, 64'(fire_tmo), 64'(v.exp_recv ? -1 : v.exp_fire));
    check({v.name, ":tmo_count"}, 64'(n_tmo), 64'(v.exp_recv ? 0 : 1));
    check({v.name, ":rearm"}, 64'({post_a, post_b}), 64'(6'b110110));
  endtask

  initial begin
    vecs[0] = '{"basic",      0,  0,  0, 1'b1,  1, 1'b1, 1'b0, 1'b1, 1'b1,  2};
    vecs[1] = '{"unbalanced", 1,  0, 40, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0,  2};
    vecs[2] = '{"late_edge",  2, 17,  0, 1'b1, 15, 1'b1, 1'b1, 1'b1, 1'b1, 16};
    vecs[3] = '{"timeout",    0,  0,  3, 1'b0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 16};
    vecs[4] = '{"mid_reply",  1,  5,  5, 1'b1,  7, 1'b1, 1'b0, 1'b1, 1'b1,  8};

    rst_n       = 1'b0;
    voice_valid = 1'b0;
    sd_valid    = 1'b0;
    voice_real  = '0;
    voice_imag  = '0;
    sd_real     = '0;
    sd_imag     = '0;
    eval_done   = 1'b0;
    eval_result = 1'b0;
    step();
    step();
    check("reset_stream", {vfr, vfi, sfr, sfi}, 64'(0));
    check("reset_ctrl",
          64'({o_start, o_receiving, o_correct, o_timeout, o_busy, voice_ready, sd_ready}),
          64'(7'b0000011));
    rst_n = 1'b1;
    step();
    check("reset_release", 64'({voice_ready, sd_ready, o_busy}), 64'(3'b110));

    for (int i = 0; i < 5; i++) run_frame(vecs[i], -1);

    // Reset while bin 100 is streaming, then a full frame from bin 0.
    run_frame(vecs[0], 100);
    run_frame(vecs[4], -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
